stream_block_packer: RTL and testbench
======================================

Name: stream_block_packer

Overview:
- Consumer end of the 16-bit valid/ready word stream produced by the single-entry pipeline buffers in the datapath.
- Collects WORDS consecutive 16-bit words and presents them as one wide block, 128 bits by default, on a downstream valid/ready port for the cipher core.
- Holds the assembled block stable until the core accepts it, then resumes filling.

Parameters:
- WORD_W, 16, width of one input word.
- WORDS, 8, words per output block. Must be ≥2. BLOCK_W = WORD_W*WORDS.
- CNT_W, 16, width of the delivered-block counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_data  in  WORD_W  input word
- s_valid  in  1  input word valid
- s_ready  out  1  packer can accept a word (registered)
- m_data  out  BLOCK_W  assembled block
- m_valid  out  1  block valid (registered)
- m_ready  in  1  downstream accepts block
- blk_cnt  out  CNT_W  count of blocks handed off

Behaviour:
- Clock is clk. Reset rst is asynchronous, active-high.
- Reset values: state=FILL, s_ready=1, m_valid=0, m_data=0, word index cnt=0, blk_cnt=0.
- Mid-operation reset discards any partial block and any held block.
- Input accept: s_valid && s_ready at a rising edge.
- Output accept: m_valid && m_ready at a rising edge.
- FILL state (s_ready=1, m_valid=0):
  - Each accepted word is written to slot cnt, then cnt increments.
  - Slot k occupies m_data[BLOCK_W-1-k*WORD_W -: WORD_W]. Word 0 is the MSB slot (big-endian block order).
  - Unwritten slots keep their prior contents. They are fully overwritten before the block is presented.
  - When the word accepted has cnt==WORDS-1: cnt becomes 0, state becomes HOLD, s_ready becomes 0 and m_valid becomes 1, all at the same edge.
  - Latency: the last word is accepted at edge N; m_valid=1 immediately after edge N.
- HOLD state (s_ready=0, m_valid=1):
  - m_data is frozen. s_valid is ignored.
  - On output accept: state becomes FILL, m_valid becomes 0, s_ready becomes 1, blk_cnt increments.
  - blk_cnt wraps modulo 2^CNT_W.
- Throughput: one bubble cycle per block. There is no same-cycle handoff from HOLD to accepting a word.
- m_ready while m_valid=0 has no effect.
- s_data is a don't-care when no accept occurs.
- The upstream protocol is honoured as-is: s_valid may drop between words, and the packer simply waits with cnt unchanged.

Optional Feature:
- Macro: STREAM_BLOCK_PACKER_LAST_EN.
- When defined, the block adds:
  - input s_last (1 bit), qualified by input accept;
  - output m_nwords ($clog2(WORDS+1) bits), registered and reset to 0.
- Accepted word with s_last=1 and cnt=c:
  - Word c is written to slot c; slots c+1..WORDS-1 are written to zero at the same edge.
  - Then enter HOLD with m_nwords=c+1, and cnt resets to 0.
- A full block without s_last presents with m_nwords=WORDS.
- s_last on slot WORDS-1 behaves identically to a normal full block.
- When not defined: the ports are absent, only full blocks are produced, and no zero padding occurs.

Decomposition:
- Shared package crypto_stream_pkg holds:
  - WORD_W default (16) and BLOCK_W default (128);
  - the packer state enum {FILL, HOLD};
  - a slot-offset function returning the MSB index for slot k.
- Single module. No sub-module is natural; the counter and slot writes are trivial.
- This module is the mirror of a future block-to-word unpacker, which shares the same package.

Test Plan:
- Reset asserted with s_valid=1 → s_ready=1, m_valid=0, m_data=0, blk_cnt=0 throughout reset.
- Words 0x0001..0x0008 back-to-back, m_ready=1 → after 8th accept, m_valid=1 for one cycle with m_data=0x0001000200030004000500060007_0008. Next cycle s_ready=1 and blk_cnt=1.
- Same 8 words, m_ready=0 for 5 cycles → m_valid and m_data stable, s_ready=0, extra s_valid pulses ignored. m_ready=1 → release, blk_cnt=1.
- Gapped s_valid (one word every 3 cycles) → identical m_data to back-to-back case; cnt does not advance on idle cycles.
- rst pulsed after 5 words accepted → next 8 words form a clean block 0x0009..0x0010 with no residue.
- With STREAM_BLOCK_PACKER_LAST_EN: 3 words 0xAAAA, 0xBBBB, 0xCCCC with s_last on the third → m_data=0xAAAABBBBCCCC followed by 80 zero bits, m_nwords=3. Drive blk_cnt wrap with CNT_W=2 over 4 blocks → blk_cnt returns to 0.

Source files
------------

// File: rtl/crypto_stream_pkg.sv
// Shared definitions for the word/block stream packer and its future unpacker.
// Word width, block width, packer state and slot placement live here.
package crypto_stream_pkg;

  localparam int DEF_WORD_W  = 16;
  localparam int DEF_BLOCK_W = 128;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Slot 0 sits in the MSBs (big-endian block order).
  function automatic int slot_msb(
    input int block_w,
    input int word_w,
    input int k
  );
    return block_w - 1 - k * word_w;
  endfunction

endpackage

// File: rtl/stream_block_packer.sv
// Packs WORDS consecutive stream words into one wide block with valid/ready.
// Define STREAM_BLOCK_PACKER_LAST_EN to add s_last short blocks and m_nwords.
module stream_block_packer
  import crypto_stream_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int WORDS  = DEF_BLOCK_W / DEF_WORD_W,
  parameter int CNT_W  = 16,
  localparam int BLOCK_W = WORD_W * WORDS,
  localparam int IDX_W   = $clog2(WORDS),
  localparam int BIT_W   = $clog2(BLOCK_W),
  localparam int NW_W    = $clog2(WORDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
`ifdef STREAM_BLOCK_PACKER_LAST_EN
  input  logic               s_last,
  output logic [NW_W-1:0]    m_nwords,
`endif
  output logic [BLOCK_W-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CNT_W-1:0]   blk_cnt
);

  pack_state_e        r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic [BLOCK_W-1:0] r_data;
  logic               r_s_ready;
  logic               r_m_valid;
  logic [CNT_W-1:0]   r_blk_cnt;
  logic               w_s_acc;
  logic               w_m_acc;
  logic               w_end;
`ifdef STREAM_BLOCK_PACKER_LAST_EN
  logic [NW_W-1:0]    r_nwords;

  assign w_end    = (r_cnt == IDX_W'(WORDS - 1)) || s_last;
  assign m_nwords = r_nwords;
`else
  assign w_end    = (r_cnt == IDX_W'(WORDS - 1));
`endif

  assign w_s_acc = (r_state == FILL) && s_valid;
  assign w_m_acc = (r_state == HOLD) && m_ready;
  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_data;
  assign blk_cnt = r_blk_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FILL;
      r_cnt     <= '0;
      r_data    <= '0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_blk_cnt <= '0;
`ifdef STREAM_BLOCK_PACKER_LAST_EN
      r_nwords  <= '0;
`endif
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_s_acc) begin
            for (int k = 0; k < WORDS; k++) begin
              if (IDX_W'(k) == r_cnt)
                r_data[BIT_W'(slot_msb(BLOCK_W, WORD_W, k)) -: WORD_W] <= s_data;
`ifdef STREAM_BLOCK_PACKER_LAST_EN
              // A short block zero-fills every slot behind the last word.
              else if (s_last && (IDX_W'(k) > r_cnt))
                r_data[BIT_W'(slot_msb(BLOCK_W, WORD_W, k)) -: WORD_W] <= '0;
`endif
            end
            if (w_end) begin
              r_cnt     <= '0;
              r_state   <= HOLD;
              r_s_ready <= 1'b0;
              r_m_valid <= 1'b1;
`ifdef STREAM_BLOCK_PACKER_LAST_EN
              r_nwords  <= NW_W'(r_cnt) + NW_W'(1);
`endif
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (w_m_acc) begin
            r_state   <= FILL;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_blk_cnt <= r_blk_cnt + CNT_W'(1);
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_block_packer.sv
// Directed self-checking bench for stream_block_packer.
// A second instance with a 2-bit block counter shares all inputs to show wrap.
module tb_stream_block_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic         s_last;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic [15:0]  blk_cnt;
  logic         w_s_ready;
  logic [127:0] w_m_data;
  logic         w_m_valid;
  logic [1:0]   w_blk_cnt;
`ifdef STREAM_BLOCK_PACKER_LAST_EN
  logic [3:0]   m_nwords;
  logic [3:0]   w_m_nwords;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] BLK_A = 128'h0001000200030004000500060007_0008;
  localparam logic [127:0] BLK_B = 128'h0009000A000B000C000D000E000F_0010;

  always #5 clk = ~clk;

  stream_block_packer #(.WORD_W(16), .WORDS(8), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
`ifdef STREAM_BLOCK_PACKER_LAST_EN
    .s_last  (s_last),
    .m_nwords(m_nwords),
`endif
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .blk_cnt (blk_cnt)
  );

  stream_block_packer #(.WORD_W(16), .WORDS(8), .CNT_W(2)) u_wrap (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (w_s_ready),
`ifdef STREAM_BLOCK_PACKER_LAST_EN
    .s_last  (s_last),
    .m_nwords(w_m_nwords),
`endif
    .m_data  (w_m_data),
    .m_valid (w_m_valid),
    .m_ready (m_ready),
    .blk_cnt (w_blk_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input logic last);
    s_data  = w;
    s_valid = 1'b1;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    s_data  = 16'h1234;
    s_valid = 1'b1;
    s_last  = 1'b0;
    m_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_s_ready", 128'(s_ready), 128'(1'b1));
      chk("rst_m_valid", 128'(m_valid), 128'(1'b0));
      chk("rst_m_data", m_data, 128'h0);
      chk("rst_blk_cnt", 128'(blk_cnt), 128'h0);
    end
    s_valid = 1'b0;
    rst     = 1'b0;
    tick();

    // back-to-back, downstream always ready
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    chk("b2b_m_valid", 128'(m_valid), 128'(1'b1));
    chk("b2b_m_data", m_data, BLK_A);
    chk("b2b_s_ready", 128'(s_ready), 128'(1'b0));
    chk("b2b_blk_pre", 128'(blk_cnt), 128'h0);
    tick();
    chk("b2b_m_valid_off", 128'(m_valid), 128'(1'b0));
    chk("b2b_s_ready_on", 128'(s_ready), 128'(1'b1));
    chk("b2b_blk_cnt", 128'(blk_cnt), 128'h1);

    // downstream stall with s_valid noise
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 16'hFFFF;
      tick();
      chk("stall_m_valid", 128'(m_valid), 128'(1'b1));
      chk("stall_m_data", m_data, BLK_A);
      chk("stall_s_ready", 128'(s_ready), 128'(1'b0));
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("stall_release", 128'(m_valid), 128'(1'b0));
    chk("stall_blk_cnt", 128'(blk_cnt), 128'h2);

    // gapped input, one word every 3 cycles
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 1'b0);
      if (i < 8) begin
        tick();
        tick();
        chk("gap_wait_valid", 128'(m_valid), 128'(1'b0));
      end
    end
    chk("gap_m_valid", 128'(m_valid), 128'(1'b1));
    chk("gap_m_data", m_data, BLK_A);
    m_ready = 1'b1;
    tick();
    chk("gap_blk_cnt", 128'(blk_cnt), 128'h3);
    chk("wrap_pre", 128'(w_blk_cnt), 128'h3);

    // reset mid-block discards partial data
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(16'hDEA0 + 16'(i), 1'b0);
    rst = 1'b1;
    #2;
    chk("mid_rst_m_data", m_data, 128'h0);
    chk("mid_rst_blk_cnt", 128'(blk_cnt), 128'h0);
    chk("mid_rst_s_ready", 128'(s_ready), 128'(1'b1));
    rst = 1'b0;
    tick();
    for (int i = 9; i <= 16; i++) send(16'(i), 1'b0);
    chk("clean_m_valid", 128'(m_valid), 128'(1'b1));
    chk("clean_m_data", m_data, BLK_B);
    m_ready = 1'b1;
    tick();
    chk("clean_blk_cnt", 128'(blk_cnt), 128'h1);

    // three more blocks: 2-bit counter wraps to 0 at 4
    for (int b = 0; b < 3; b++) begin
      for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
      tick();
    end
    chk("wrap_main", 128'(blk_cnt), 128'h4);
    chk("wrap_2bit", 128'(w_blk_cnt), 128'h0);

`ifdef STREAM_BLOCK_PACKER_LAST_EN
    m_ready = 1'b0;
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    send(16'hCCCC, 1'b1);
    chk("last_m_valid", 128'(m_valid), 128'(1'b1));
    chk("last_m_data", m_data, {48'hAAAABBBBCCCC, 80'h0});
    chk("last_nwords", 128'(m_nwords), 128'h3);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    chk("full_nwords", 128'(m_nwords), 128'h8);
    chk("full_m_data", m_data, BLK_A);
    m_ready = 1'b1;
    tick();
    for (int i = 9; i <= 16; i++) send(16'(i), i == 16);
    chk("last7_nwords", 128'(m_nwords), 128'h8);
    chk("last7_m_data", m_data, BLK_B);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
